// File: rtl/iob_ram_bist_pkg.sv
// iob_ram_bist_pkg: shared FSM state encoding for the RAM BIST controller.
package iob_ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ZREAD = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_t;

endpackage

// File: rtl/iob_ram_bist_if.sv
// iob_ram_bist_if: RAM-side bus between the BIST controller (master) and the RAM (slave).
interface iob_ram_bist_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic              w_en_o;
  logic              r_en_o;
  logic [DATA_W-1:0] w_data_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] r_data_i;

  modport master (output w_en_o, r_en_o, w_data_o, addr_o, input r_data_i);
  modport slave  (input w_en_o, r_en_o, w_data_o, addr_o, output r_data_i);
endinterface

// File: rtl/iob_ram_bist_chk.sv
// iob_ram_bist_chk: aligns expected data/address with the one-cycle read latency,
// compares against returned data and keeps a saturating error count plus first-fail address.
module iob_ram_bist_chk
  import iob_ram_bist_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int ERR_W  = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] r_data_i,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic              clean_o
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              mism_s;

  // Pipeline stage update, mismatch detection and error bookkeeping.
  always_comb begin
    vld_d  = vld_i;
    exp_d  = exp_i;
    addr_d = addr_i;
    err_d  = err_q;
    fail_d = fail_q;
    mism_s = vld_q && (r_data_i != exp_q);
    if (clr_i) begin
      vld_d  = 1'b0;
      err_d  = {ERR_W{1'b0}};
      fail_d = {ADDR_W{1'b0}};
    end else if (mism_s) begin
      if (err_q == {ERR_W{1'b0}}) begin
        fail_d = addr_q;
      end else begin
        fail_d = fail_q;
      end
      if (err_q != ERR_MAX) begin
        err_d = err_q + ERR_W'(1'b1);
      end else begin
        err_d = err_q;
      end
    end else begin
      err_d  = err_q;
      fail_d = fail_q;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_q  <= 1'b0;
      exp_q  <= {DATA_W{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
      err_q  <= {ERR_W{1'b0}};
      fail_q <= {ADDR_W{1'b0}};
    end else begin
      vld_q  <= vld_d;
      exp_q  <= exp_d;
      addr_q <= addr_d;
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

  assign err_cnt_o   = err_q;
  assign fail_addr_o = fail_q;
  assign clean_o     = (err_d == {ERR_W{1'b0}});

endmodule

// File: rtl/iob_ram_t2p_tiled.sv
// iob_ram_t2p_tiled: two-port RAM built from 2^TILE_ADDR_W-word tiles; one-cycle
// registered read, read data is 0 in the cycle after r_en_i was low.
module iob_ram_t2p_tiled #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 13,
  parameter int TILE_ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              w_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o
);

  localparam int TSEL_W  = ADDR_W - TILE_ADDR_W;
  localparam int N_TILES = 2 ** TSEL_W;

  logic [DATA_W-1:0] tile_rd_s [N_TILES];
  logic [TSEL_W-1:0] rsel_q;
  logic              r_en_q;

  for (genvar t = 0; t < N_TILES; t++) begin : g_tile
    logic [DATA_W-1:0] mem [2**TILE_ADDR_W];
    logic [DATA_W-1:0] rd_q;

    // Tile write port and registered read port.
    always_ff @(posedge clk_i) begin
      if (w_en_i && (w_addr_i[ADDR_W-1:TILE_ADDR_W] == TSEL_W'(t))) begin
        mem[w_addr_i[TILE_ADDR_W-1:0]] <= w_data_i;
      end
      if (r_en_i && (r_addr_i[ADDR_W-1:TILE_ADDR_W] == TSEL_W'(t))) begin
        rd_q <= mem[r_addr_i[TILE_ADDR_W-1:0]];
      end
    end

    assign tile_rd_s[t] = rd_q;
  end

  // Remember which tile was read and whether a read happened at all.
  always_ff @(posedge clk_i) begin
    r_en_q <= r_en_i;
    rsel_q <= r_addr_i[ADDR_W-1:TILE_ADDR_W];
  end

  assign r_data_o = r_en_q ? tile_rd_s[rsel_q] : {DATA_W{1'b0}};

endmodule

// File: rtl/iob_ram_bist.sv
// iob_ram_bist: RAM BIST controller. Writes an incrementing pattern to every address,
// optionally checks that un-enabled reads return 0 (IOB_RAM_BIST_ZCHK_EN), then reads
// everything back and reports pass/fail, error count and first failing address.
module iob_ram_bist
  import iob_ram_bist_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 13,
  parameter int SEQ_INI = 32,
  parameter int ERR_W   = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  iob_ram_bist_if.master    ram_bus
);

  function automatic logic [DATA_W-1:0] pat_f(input logic [ADDR_W-1:0] a);
    pat_f = DATA_W'(a) + DATA_W'(SEQ_INI);
  endfunction

  bist_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              w_en_q, w_en_d;
  logic              r_en_q, r_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_exp_q, rd_exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              clr_s;
  logic              last_s;
  logic              chk_clean_s;

  assign last_s = (cnt_q == {ADDR_W{1'b1}});

  // Next-state/counter logic, then registered-output decode from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_s    = 1'b0;
    w_en_d   = 1'b0;
    r_en_d   = 1'b0;
    addr_d   = {ADDR_W{1'b0}};
    w_data_d = {DATA_W{1'b0}};
    rd_vld_d = 1'b0;
    rd_exp_d = {DATA_W{1'b0}};
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          clr_s   = 1'b1;
          state_d = ST_WRITE;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + ADDR_W'(1'b1);
        if (last_s) begin
`ifdef IOB_RAM_BIST_ZCHK_EN
          state_d = ST_ZREAD;
`else
          state_d = ST_READ;
`endif
        end else begin
          state_d = ST_WRITE;
        end
      end
`ifdef IOB_RAM_BIST_ZCHK_EN
      ST_ZREAD: begin
        cnt_d = cnt_q + ADDR_W'(1'b1);
        if (last_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_ZREAD;
        end
      end
`endif
      ST_READ: begin
        cnt_d = cnt_q + ADDR_W'(1'b1);
        if (last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        cnt_d   = {ADDR_W{1'b0}};
        state_d = ST_DONE;
      end
      default: begin
        cnt_d   = {ADDR_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_WRITE: begin
        busy_d   = 1'b1;
        w_en_d   = 1'b1;
        addr_d   = cnt_d;
        w_data_d = pat_f(cnt_d);
      end
`ifdef IOB_RAM_BIST_ZCHK_EN
      ST_ZREAD: begin
        busy_d   = 1'b1;
        addr_d   = cnt_d;
        rd_vld_d = 1'b1;
        rd_exp_d = {DATA_W{1'b0}};
      end
`endif
      ST_READ: begin
        busy_d   = 1'b1;
        r_en_d   = 1'b1;
        addr_d   = cnt_d;
        rd_vld_d = 1'b1;
        rd_exp_d = pat_f(cnt_d);
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // The error count seen on entry to DONE already includes the final (drain) compare.
  assign pass_d = (state_d == ST_DONE) && chk_clean_s;

  // State, counter and registered output flops.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {ADDR_W{1'b0}};
      w_en_q   <= 1'b0;
      r_en_q   <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      w_data_q <= {DATA_W{1'b0}};
      rd_vld_q <= 1'b0;
      rd_exp_q <= {DATA_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_en_q   <= w_en_d;
      r_en_q   <= r_en_d;
      addr_q   <= addr_d;
      w_data_q <= w_data_d;
      rd_vld_q <= rd_vld_d;
      rd_exp_q <= rd_exp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  iob_ram_bist_chk #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ERR_W  (ERR_W)
  ) u_chk (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .clr_i       (clr_s),
    .vld_i       (rd_vld_q),
    .exp_i       (rd_exp_q),
    .addr_i      (addr_q),
    .r_data_i    (ram_bus.r_data_i),
    .err_cnt_o   (err_cnt_o),
    .fail_addr_o (fail_addr_o),
    .clean_o     (chk_clean_s)
  );

  assign ram_bus.w_en_o   = w_en_q;
  assign ram_bus.r_en_o   = r_en_q;
  assign ram_bus.addr_o   = addr_q;
  assign ram_bus.w_data_o = w_data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;

endmodule
